// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the loadable countdown timer: FSM state encoding and width.
package countdown_timer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'b00,
    LOADED = 2'b01,
    RUN    = 2'b10,
    DONE   = 2'b11
  } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer; the master drives commands,
// the slave (the timer) returns count, status and debug state.
interface countdown_timer_if
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic               enable;
  logic               load;
  logic [WIDTH-1:0]   load_value;
  logic               start;
  logic               abort;
  logic               ack;
  logic [WIDTH-1:0]   counter_out;
  logic               busy;
  logic               done;
  logic [STATE_W-1:0] state_out;

  modport master (
    output enable, load, load_value, start, abort, ack,
    input  counter_out, busy, done, state_out
  );

  modport slave (
    input  enable, load, load_value, start, abort, ack,
    output counter_out, busy, done, state_out
  );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count flag; optional auto-reload turns it
// into a periodic tick source with a one-cycle done pulse.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic               clock,
  input logic               reset,
  countdown_timer_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  // Next-state logic; priority is abort > load > start > ack > enable.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = done_q;

    if (bus.abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.load) begin
            count_d  = bus.load_value;
            reload_d = bus.load_value;
            state_d  = LOADED;
          end
        end

        LOADED: begin
          if (bus.load) begin
            count_d  = bus.load_value;
            reload_d = bus.load_value;
          end else if (bus.start) begin
            if (count_q == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end

        RUN: begin
          // In auto-reload mode done is a single-cycle pulse, so drop it by default.
          done_d = 1'b0;
          if (bus.enable) begin
            if (count_q != CNT_ONE) begin
              count_d = count_q - CNT_ONE;
            end else if (AUTO_RELOAD) begin
              count_d = reload_q;
              done_d  = 1'b1;
            end else begin
              count_d = '0;
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end

        DONE: begin
          if (bus.load) begin
            count_d  = bus.load_value;
            reload_d = bus.load_value;
            done_d   = 1'b0;
            state_d  = LOADED;
          end else if (bus.ack) begin
            done_d  = 1'b0;
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign bus.counter_out = count_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q == RUN);
  assign bus.state_out   = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: one non-reload and one auto-reload timer driven by the
// same command stream, checked against directed expectations and a count model.
module tb_countdown_timer;

  localparam int WIDTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             load = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             ack = 1'b0;
  logic [WIDTH-1:0] load_value = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  countdown_timer_if #(.WIDTH(WIDTH)) bus0 ();
  countdown_timer_if #(.WIDTH(WIDTH)) bus1 ();

  assign bus0.enable     = enable;
  assign bus0.load       = load;
  assign bus0.load_value = load_value;
  assign bus0.start      = start;
  assign bus0.abort      = abort;
  assign bus0.ack        = ack;
  assign bus1.enable     = enable;
  assign bus1.load       = load;
  assign bus1.load_value = load_value;
  assign bus1.start      = start;
  assign bus1.abort      = abort;
  assign bus1.ack        = ack;

  countdown_timer #(.WIDTH(WIDTH), .AUTO_RELOAD(1'b0)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  countdown_timer #(.WIDTH(WIDTH), .AUTO_RELOAD(1'b1)) u_dut_ar (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  // Observation packed as {counter_out, state_out, done, busy}.
  function automatic logic [7:0] obs0();
    return {bus0.counter_out, bus0.state_out, bus0.done, bus0.busy};
  endfunction

  function automatic logic [7:0] obs1();
    return {bus1.counter_out, bus1.state_out, bus1.done, bus1.busy};
  endfunction

  // Apply one set of commands across exactly one rising edge, then release them.
  task automatic cycle(input logic en, input logic ld, input logic st,
                       input logic ab, input logic ak, input logic [WIDTH-1:0] v);
    enable = en; load = ld; start = st; abort = ab; ack = ak; load_value = v;
    @(posedge clock);
    #1;
    enable = 1'b0; load = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    e = {4'd0, 2'b00, 1'b0, 1'b0};
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++; if (obs0() !== e) begin failures++; $display("FAIL reset_init got=%h exp=%h", obs0(), e); end
    checks++; if (obs1() !== e) begin failures++; $display("FAIL reset_init_ar got=%h exp=%h", obs1(), e); end
    reset = 1'b0;

    cycle(0, 1, 0, 0, 0, 4'd9);
    cycle(1, 0, 1, 0, 0, 4'd0);
    cycle(1, 0, 0, 0, 0, 4'd0);
    cycle(1, 0, 0, 0, 0, 4'd0);
    e = {4'd7, 2'b10, 1'b0, 1'b1};
    checks++; if (obs0() !== e) begin failures++; $display("FAIL reset_prerun got=%h exp=%h", obs0(), e); end

    enable = 1'b1;
    reset  = 1'b1;
    @(posedge clock); #1;
    e = {4'd0, 2'b00, 1'b0, 1'b0};
    checks++; if (obs0() !== e) begin failures++; $display("FAIL reset_midrun got=%h exp=%h", obs0(), e); end
    checks++; if (obs1() !== e) begin failures++; $display("FAIL reset_midrun_ar got=%h exp=%h", obs1(), e); end
    @(posedge clock); #1;
    checks++; if (obs0() !== e) begin failures++; $display("FAIL reset_hold got=%h exp=%h", obs0(), e); end
    reset  = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] e;
    cycle(0, 0, 0, 1, 0, 4'd0);
    cycle(0, 1, 0, 0, 0, 4'd5);
    e = {4'd5, 2'b01, 1'b0, 1'b0};
    checks++; if (obs0() !== e) begin failures++; $display("FAIL basic_loaded got=%h exp=%h", obs0(), e); end
    cycle(1, 0, 1, 0, 0, 4'd0);
    e = {4'd5, 2'b10, 1'b0, 1'b1};
    checks++; if (obs0() !== e) begin failures++; $display("FAIL basic_started got=%h exp=%h", obs0(), e); end
    for (int i = 1; i <= 5; i++) begin
      cycle(1, 0, 0, 0, 0, 4'd0);
      e = (i < 5) ? {4'(5 - i), 2'b10, 1'b0, 1'b1} : {4'd0, 2'b11, 1'b1, 1'b0};
      checks++; if (obs0() !== e) begin failures++; $display("FAIL basic_step%0d got=%h exp=%h", i, obs0(), e); end
    end
    cycle(1, 0, 0, 0, 0, 4'd0);
    cycle(0, 0, 0, 0, 0, 4'd0);
    e = {4'd0, 2'b11, 1'b1, 1'b0};
    checks++; if (obs0() !== e) begin failures++; $display("FAIL basic_done_hold got=%h exp=%h", obs0(), e); end
    cycle(0, 0, 0, 0, 1, 4'd0);
    e = {4'd0, 2'b00, 1'b0, 1'b0};
    checks++; if (obs0() !== e) begin failures++; $display("FAIL basic_ack got=%h exp=%h", obs0(), e); end
  endtask

  task automatic test_enable_gating();
    logic [7:0] e;
    logic [3:0] exp_cnt [5] = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
    logic       pat [5]     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    cycle(0, 0, 0, 1, 0, 4'd0);
    cycle(0, 1, 0, 0, 0, 4'd3);
    cycle(0, 0, 1, 0, 0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(pat[i], 0, 0, 0, 0, 4'd0);
      e = (i < 4) ? {exp_cnt[i], 2'b10, 1'b0, 1'b1} : {exp_cnt[i], 2'b11, 1'b1, 1'b0};
      checks++; if (obs0() !== e) begin failures++; $display("FAIL gate_step%0d got=%h exp=%h", i, obs0(), e); end
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] e;
    cycle(0, 0, 0, 1, 0, 4'd0);
    cycle(0, 1, 0, 0, 0, 4'd2);
    cycle(0, 0, 1, 0, 0, 4'd0);
    e = {4'd2, 2'b10, 1'b0, 1'b1};
    checks++; if (obs1() !== e) begin failures++; $display("FAIL ar_started got=%h exp=%h", obs1(), e); end
    for (int i = 1; i <= 6; i++) begin
      cycle(1, 0, 0, 0, 0, 4'd0);
      e = (i % 2 == 1) ? {4'd1, 2'b10, 1'b0, 1'b1} : {4'd2, 2'b10, 1'b1, 1'b1};
      checks++; if (obs1() !== e) begin failures++; $display("FAIL ar_step%0d got=%h exp=%h", i, obs1(), e); end
    end
    cycle(0, 0, 0, 0, 0, 4'd0);
    e = {4'd2, 2'b10, 1'b0, 1'b1};
    checks++; if (obs1() !== e) begin failures++; $display("FAIL ar_pulse_end got=%h exp=%h", obs1(), e); end
  endtask

  task automatic test_boundaries();
    logic [7:0] e;
    cycle(0, 0, 0, 1, 0, 4'd0);
    cycle(0, 1, 0, 0, 0, 4'd0);
    cycle(0, 0, 1, 0, 0, 4'd0);
    e = {4'd0, 2'b11, 1'b1, 1'b0};
    checks++; if (obs0() !== e) begin failures++; $display("FAIL zero_start got=%h exp=%h", obs0(), e); end
    checks++; if (obs1() !== e) begin failures++; $display("FAIL zero_start_ar got=%h exp=%h", obs1(), e); end

    cycle(0, 1, 0, 0, 1, 4'd9);
    e = {4'd9, 2'b01, 1'b0, 1'b0};
    checks++; if (obs0() !== e) begin failures++; $display("FAIL load_ack got=%h exp=%h", obs0(), e); end

    cycle(0, 0, 0, 1, 0, 4'd0);
    cycle(0, 1, 0, 0, 0, 4'd15);
    cycle(0, 0, 1, 0, 0, 4'd0);
    for (int i = 1; i <= 14; i++) cycle(1, 0, 0, 0, 0, 4'd0);
    e = {4'd1, 2'b10, 1'b0, 1'b1};
    checks++; if (obs0() !== e) begin failures++; $display("FAIL max_pre got=%h exp=%h", obs0(), e); end
    cycle(1, 0, 0, 0, 0, 4'd0);
    e = {4'd0, 2'b11, 1'b1, 1'b0};
    checks++; if (obs0() !== e) begin failures++; $display("FAIL max_done got=%h exp=%h", obs0(), e); end
    e = {4'd15, 2'b10, 1'b1, 1'b1};
    checks++; if (obs1() !== e) begin failures++; $display("FAIL max_reload_ar got=%h exp=%h", obs1(), e); end
  endtask

  task automatic test_abort();
    logic [7:0] e;
    cycle(0, 0, 0, 1, 0, 4'd0);
    cycle(0, 1, 0, 0, 0, 4'd4);
    cycle(0, 0, 1, 1, 0, 4'd0);
    e = {4'd4, 2'b00, 1'b0, 1'b0};
    checks++; if (obs0() !== e) begin failures++; $display("FAIL abort_loaded got=%h exp=%h", obs0(), e); end

    cycle(0, 1, 0, 0, 0, 4'd4);
    cycle(0, 0, 1, 0, 0, 4'd0);
    cycle(1, 0, 0, 0, 0, 4'd0);
    cycle(1, 0, 0, 0, 0, 4'd0);
    cycle(1, 0, 0, 1, 0, 4'd0);
    e = {4'd2, 2'b00, 1'b0, 1'b0};
    checks++; if (obs0() !== e) begin failures++; $display("FAIL abort_run got=%h exp=%h", obs0(), e); end

    cycle(0, 1, 0, 0, 0, 4'd0);
    cycle(0, 0, 1, 0, 0, 4'd0);
    cycle(0, 0, 0, 1, 1, 4'd0);
    e = {4'd0, 2'b00, 1'b0, 1'b0};
    checks++; if (obs0() !== e) begin failures++; $display("FAIL abort_done got=%h exp=%h", obs0(), e); end
  endtask

  // Count model: after k enabled RUN cycles from start value n, the one-shot timer
  // shows max(n-k,0) and is done once k>=n; the reloading one shows n-(k mod n)
  // and pulses done on the enabled edge where k becomes a multiple of n.
  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int         n;
      int         k;
      int         cyc;
      logic       en;
      logic       jl;
      logic       js;
      logic       ja;
      logic [7:0] e0;
      logic [7:0] e1;
      n   = $urandom_range(1, 15);
      k   = 0;
      cyc = 0;
      cycle(0, 0, 0, 1, 0, 4'd0);
      cycle(0, 1, 0, 0, 0, 4'(n));
      cycle(0, 0, 1, 0, 0, 4'd0);
      while (k < 2 * n && cyc < 200) begin
        en = 1'($urandom_range(0, 1));
        jl = 1'b0; js = 1'b0; ja = 1'b0;
        if (k < n) begin
          jl = ($urandom_range(0, 3) == 0);
          js = ($urandom_range(0, 3) == 0);
          ja = ($urandom_range(0, 3) == 0);
        end
        cycle(en, jl, js, 1'b0, ja, 4'($urandom));
        cyc++;
        if (en) k++;
        e0 = (k >= n) ? {4'd0, 2'b11, 1'b1, 1'b0} : {4'(n - k), 2'b10, 1'b0, 1'b1};
        e1 = {4'(n - (k % n)), 2'b10, en && (k % n == 0), 1'b1};
        checks++; if (obs0() !== e0) begin failures++; $display("FAIL rand%0d_cyc%0d got=%h exp=%h", t, cyc, obs0(), e0); end
        checks++; if (obs1() !== e1) begin failures++; $display("FAIL rand%0d_ar_cyc%0d got=%h exp=%h", t, cyc, obs1(), e1); end
      end
      checks++;
      if (k < 2 * n) begin failures++; $display("FAIL rand%0d_budget got=%0d exp=%0d", t, k, 2 * n); end
      cycle(0, 0, 0, 0, 1, 4'd0);
      e0 = {4'd0, 2'b00, 1'b0, 1'b0};
      checks++; if (obs0() !== e0) begin failures++; $display("FAIL rand%0d_ack got=%h exp=%h", t, obs0(), e0); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_enable_gating();
    test_auto_reload();
    test_boundaries();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
